// File: rtl/mc_pc_sequencer.sv
// Program counter / sequencer: produces the fetch line from stall, jump and sleep controls.
// Latency: pc, fetch_valid and sleeping are registered (1 edge); stalled is combinational.
// Backpressure: increment_pc=0 holds pc and drops decode controls; SLEEP ignores everything but tick.
module mc_pc_sequencer #(
    parameter int PC_WIDTH   = 4,
    parameter int DATA_WIDTH = 11,
    parameter int MAX_SLEEP  = 999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  increment_pc,
    input  logic                  jump_en,
    input  logic [PC_WIDTH-1:0]   jump_addr,
    input  logic                  sleep_en,
    input  logic [DATA_WIDTH-1:0] sleep_count,
    input  logic                  tick,
    input  logic [PC_WIDTH-1:0]   prog_len,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  fetch_valid,
    output logic                  sleeping,
    output logic                  stalled
);

    localparam int CNT_W = $clog2(MAX_SLEEP + 1);
    localparam logic [DATA_WIDTH-1:0] MAX_D = DATA_WIDTH'(MAX_SLEEP);
    localparam logic [CNT_W-1:0]      MAX_C = CNT_W'(MAX_SLEEP);

    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [CNT_W-1:0]    sleep_cnt, sleep_cnt_nxt;
    logic                fetch_valid_nxt;
    logic                sleeping_nxt;

    logic [PC_WIDTH:0]   pc_inc;
    logic [PC_WIDTH-1:0] pc_adv;
    logic [PC_WIDTH-1:0] jump_tgt;
    logic                sleep_pos;
    logic [CNT_W-1:0]    sleep_load;

    // Extra bit on the increment so pc=max never aliases to a small value before the wrap compare.
    assign pc_inc     = {1'b0, pc} + {{PC_WIDTH{1'b0}}, 1'b1};
    assign pc_adv     = (pc_inc >= {1'b0, prog_len}) ? '0 : pc_inc[PC_WIDTH-1:0];
    assign jump_tgt   = (jump_addr < prog_len) ? jump_addr : '0;
    assign sleep_pos  = !sleep_count[DATA_WIDTH-1] && (sleep_count != '0);
    assign sleep_load = (sleep_count > MAX_D) ? MAX_C : CNT_W'(sleep_count);

    assign stalled = (state == RUN) && !increment_pc;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        sleep_cnt_nxt   = sleep_cnt;
        fetch_valid_nxt = fetch_valid;
        sleeping_nxt    = sleeping;
        unique case (state)
            RUN: begin
                if (prog_len == '0) begin
                    pc_nxt          = '0;
                    fetch_valid_nxt = 1'b0;
                end else if (!fetch_valid) begin
                    // Bubble edge: pc is already 0, line 0 becomes valid without advancing.
                    fetch_valid_nxt = 1'b1;
                end else if (!increment_pc) begin
                    pc_nxt = pc;
                end else if (sleep_en) begin
                    pc_nxt = pc_adv;
                    if (sleep_pos) begin
                        sleep_cnt_nxt   = sleep_load;
                        state_nxt       = SLEEP;
                        sleeping_nxt    = 1'b1;
                        fetch_valid_nxt = 1'b0;
                    end
                end else if (jump_en) begin
                    pc_nxt = jump_tgt;
                end else begin
                    pc_nxt = pc_adv;
                end
            end
            SLEEP: begin
                if (tick) begin
                    sleep_cnt_nxt = sleep_cnt - CNT_W'(1);
                    if (sleep_cnt == CNT_W'(1)) begin
                        state_nxt       = RUN;
                        sleeping_nxt    = 1'b0;
                        fetch_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= '0;
            sleep_cnt   <= '0;
            fetch_valid <= 1'b0;
            sleeping    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            sleep_cnt   <= sleep_cnt_nxt;
            fetch_valid <= fetch_valid_nxt;
            sleeping    <= sleeping_nxt;
        end
    end

endmodule

// File: tb/tb_mc_pc_sequencer.sv
// Directed bench for mc_pc_sequencer; expected outputs are queued per edge and checked by a monitor.
module tb_mc_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        increment_pc;
    logic        jump_en;
    logic [3:0]  jump_addr;
    logic        sleep_en;
    logic [10:0] sleep_count;
    logic        tick;
    logic [3:0]  prog_len;
    logic [3:0]  pc;
    logic        fetch_valid;
    logic        sleeping;
    logic        stalled;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [3:0] pc;
        logic       fv;
        logic       sl;
        logic       st;
    } exp_t;

    exp_t sb[$];

    mc_pc_sequencer #(
        .PC_WIDTH  (4),
        .DATA_WIDTH(11),
        .MAX_SLEEP (999)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .increment_pc(increment_pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .sleep_en    (sleep_en),
        .sleep_count (sleep_count),
        .tick        (tick),
        .prog_len    (prog_len),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .sleeping    (sleeping),
        .stalled     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock edge with the currently driven inputs; queue what the outputs must show afterwards.
    task automatic step(input string nm, input logic [3:0] epc, input logic efv,
                        input logic esl, input logic est);
        exp_t e;
        @(posedge clk);
        e.name = nm;
        e.pc   = epc;
        e.fv   = efv;
        e.sl   = esl;
        e.st   = est;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".pc"},          int'(pc),          int'(e.pc));
                chk({e.name, ".fetch_valid"}, int'(fetch_valid), int'(e.fv));
                chk({e.name, ".sleeping"},    int'(sleeping),    int'(e.sl));
                chk({e.name, ".stalled"},     int'(stalled),     int'(e.st));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin : stim
        reset        = 1'b1;
        increment_pc = 1'b1;
        jump_en      = 1'b0;
        jump_addr    = 4'd0;
        sleep_en     = 1'b0;
        sleep_count  = 11'd0;
        tick         = 1'b0;
        prog_len     = 4'd3;

        step("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Sequential fetch with wrap at prog_len=3
        step("bubble", 4'd0, 1'b1, 1'b0, 1'b0);
        step("seq1",   4'd1, 1'b1, 1'b0, 1'b0);
        step("seq2",   4'd2, 1'b1, 1'b0, 1'b0);
        step("wrap",   4'd0, 1'b1, 1'b0, 1'b0);
        step("seq1b",  4'd1, 1'b1, 1'b0, 1'b0);

        // Stall at pc=1, decode controls ignored while stalled
        increment_pc = 1'b0;
        jump_en      = 1'b1;
        jump_addr    = 4'd0;
        for (int i = 0; i < 3; i++) step("stall", 4'd1, 1'b1, 1'b0, 1'b1);
        increment_pc = 1'b1;
        jump_en      = 1'b0;
        step("release", 4'd2, 1'b1, 1'b0, 1'b0);

        // Jumps with prog_len=4
        prog_len  = 4'd4;
        jump_en   = 1'b1;
        jump_addr = 4'd5;
        step("jmp_oob", 4'd0, 1'b1, 1'b0, 1'b0);
        jump_addr = 4'd2;
        step("jmp2",    4'd2, 1'b1, 1'b0, 1'b0);
        jump_addr = 4'd3;
        step("jmp_last", 4'd3, 1'b1, 1'b0, 1'b0);
        jump_addr = 4'd4;
        step("jmp_eq_len", 4'd0, 1'b1, 1'b0, 1'b0);

        // Jump and sleep together: sleep wins, pc advances
        jump_addr   = 4'd3;
        sleep_en    = 1'b1;
        sleep_count = 11'd1;
        step("sj_sleep", 4'd1, 1'b0, 1'b1, 1'b0);
        jump_en  = 1'b0;
        sleep_en = 1'b0;
        tick     = 1'b1;
        step("sj_wake",  4'd1, 1'b1, 1'b0, 1'b0);

        // Sleep 3 from pc=4, prog_len=6; entry-edge tick not counted
        prog_len  = 4'd6;
        tick      = 1'b0;
        jump_en   = 1'b1;
        jump_addr = 4'd4;
        step("jmp4", 4'd4, 1'b1, 1'b0, 1'b0);
        jump_en     = 1'b0;
        sleep_en    = 1'b1;
        sleep_count = 11'd3;
        tick        = 1'b1;
        step("sl_entry", 4'd5, 1'b0, 1'b1, 1'b0);
        sleep_en = 1'b0;
        step("sl_t1",    4'd5, 1'b0, 1'b1, 1'b0);
        tick = 1'b0;
        step("sl_notick", 4'd5, 1'b0, 1'b1, 1'b0);
        tick         = 1'b1;
        increment_pc = 1'b0;
        jump_en      = 1'b1;
        jump_addr    = 4'd0;
        step("sl_t2",    4'd5, 1'b0, 1'b1, 1'b0);
        increment_pc = 1'b1;
        jump_en      = 1'b0;
        step("sl_wake",  4'd5, 1'b1, 1'b0, 1'b0);

        // Non-positive sleep counts: no sleep, pc advances (with wrap at 6)
        tick        = 1'b0;
        sleep_en    = 1'b1;
        sleep_count = 11'h7FB;
        step("sl_neg",  4'd0, 1'b1, 1'b0, 1'b0);
        sleep_count = 11'd0;
        step("sl_zero", 4'd1, 1'b1, 1'b0, 1'b0);
        sleep_en = 1'b0;

        // prog_len shrinks under a held pc: forced to 0 on next advance
        jump_en   = 1'b1;
        jump_addr = 4'd4;
        step("jmp4b", 4'd4, 1'b1, 1'b0, 1'b0);
        jump_en      = 1'b0;
        prog_len     = 4'd3;
        increment_pc = 1'b0;
        step("stall_hi", 4'd4, 1'b1, 1'b0, 1'b1);
        increment_pc = 1'b1;
        step("force0",   4'd0, 1'b1, 1'b0, 1'b0);

        // Empty program
        prog_len = 4'd0;
        step("plen0",     4'd0, 1'b0, 1'b0, 1'b0);
        prog_len = 4'd3;
        step("plen_bub",  4'd0, 1'b1, 1'b0, 1'b0);
        step("plen_run",  4'd1, 1'b1, 1'b0, 1'b0);

        // Clamp: 1023 is the largest positive 11-bit count; wakes after 999 ticks
        sleep_en    = 1'b1;
        sleep_count = 11'd1023;
        step("big_entry", 4'd2, 1'b0, 1'b1, 1'b0);
        sleep_en = 1'b0;
        tick     = 1'b1;
        for (int i = 1; i < 999; i++) step("big_sleep", 4'd2, 1'b0, 1'b1, 1'b0);
        step("big_wake",  4'd2, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a sleep
        tick = 1'b0;
        step("w0", 4'd0, 1'b1, 1'b0, 1'b0);
        step("w1", 4'd1, 1'b1, 1'b0, 1'b0);
        sleep_en    = 1'b1;
        sleep_count = 11'd5;
        step("s5",  4'd2, 1'b0, 1'b1, 1'b0);
        sleep_en = 1'b0;
        tick     = 1'b1;
        step("s5t", 4'd2, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("async_rst.pc",          int'(pc),          0);
        chk("async_rst.sleeping",    int'(sleeping),    0);
        chk("async_rst.fetch_valid", int'(fetch_valid), 0);
        step("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick  = 1'b0;
        step("rst_bub",  4'd0, 1'b1, 1'b0, 1'b0);
        step("rst_run",  4'd1, 1'b1, 1'b0, 1'b0);

        @(posedge clk);
        #5;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
